// File: rtl/operand_stack_pkg.sv
// Shared stack op encodings, trap codes and default data width for cpu decode/trap logic
// and the operand stack.
package operand_stack_pkg;
    localparam int DATA_W_DEFAULT = 64;

    typedef enum logic [2:0] {
        STACK_OP_NOP    = 3'd0,
        STACK_OP_PUSH   = 3'd1,
        STACK_OP_POP    = 3'd2,
        STACK_OP_UNARY  = 3'd3,
        STACK_OP_BINARY = 3'd4,
        STACK_OP_DROP2  = 3'd5
    } stack_op_e;

    typedef enum logic [3:0] {
        TRAP_NONE            = 4'd0,
        TRAP_STACK_UNDERFLOW = 4'd1,
        TRAP_STACK_OVERFLOW  = 4'd2
    } trap_e;
endpackage

// File: rtl/stack_ram.sv
// One bank of operand stack backing storage: single write port, registered read port
// returning the pre-write contents.
module stack_ram #(
    parameter int AW    = 9,
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic [AW-1:0]    rd_addr,
    output logic [WIDTH-1:0] rd_data
);
    logic [WIDTH-1:0] mem_q [2**AW];
    logic [WIDTH-1:0] rd_data_q;

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_addr] <= wr_data;
        end
        rd_data_q <= mem_q[rd_addr];
    end

    assign rd_data = rd_data_q;
endmodule

// File: rtl/operand_stack.sv
// WebAssembly operand stack: tos/nos registers over a banked RAM with a one-entry shadow.
// Define OPERAND_STACK_HWM_EN to add the hwm (high-water mark) output.
module operand_stack
    import operand_stack_pkg::*;
#(
    parameter int DEPTH = 1024,
    parameter int WIDTH = DATA_W_DEFAULT
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    op_valid,
    input  logic [2:0]              op,
    input  logic [WIDTH-1:0]        din,
    output logic [WIDTH-1:0]        tos,
    output logic [WIDTH-1:0]        nos,
    output logic [$clog2(DEPTH):0]  size,
    output logic                    empty,
    output logic                    full,
    output logic [3:0]              trap
`ifdef OPERAND_STACK_HWM_EN
    ,
    output logic [$clog2(DEPTH):0]  hwm
`endif
);
    localparam int SW = $clog2(DEPTH) + 1;
    localparam int AW = $clog2(DEPTH) - 1;
    localparam int IW = AW + 1;

    logic [WIDTH-1:0] tos_q, tos_d, nos_q, nos_d, sh_q, sh_d;
    logic [SW-1:0]    size_q, size_d;
    trap_e            trap_q, trap_d;
    logic             wr_en;
    logic [IW-1:0]    wr_idx, rd4_idx, rd5_idx;
    logic [1:0][WIDTH-1:0] bank_rd;
    logic [WIDTH-1:0] r4, r5;

    // Element e lives in bank e[0] at address e>>1, so entries size-4 and size-5 are
    // always in different banks and both can be prefetched every cycle (DROP2 needs two).
    assign wr_idx  = size_q[IW-1:0] - IW'(2);
    assign rd4_idx = size_d[IW-1:0] - IW'(4);
    assign rd5_idx = size_d[IW-1:0] - IW'(5);

    for (genvar gi = 0; gi < 2; gi++) begin : g_bank
        logic [AW-1:0] rd_addr;
        assign rd_addr = (rd4_idx[0] == 1'(gi)) ? rd4_idx[IW-1:1] : rd5_idx[IW-1:1];
        stack_ram #(.AW(AW), .WIDTH(WIDTH)) u_ram (
            .clk     (clk),
            .wr_en   (wr_en && (wr_idx[0] == 1'(gi))),
            .wr_addr (wr_idx[IW-1:1]),
            .wr_data (nos_q),
            .rd_addr (rd_addr),
            .rd_data (bank_rd[gi])
        );
    end

    // Absent entries read as zero so tos/nos/shadow naturally fall to 0 near the bottom.
    always_comb begin
        r4 = size_q[0] ? bank_rd[1] : bank_rd[0];
        r5 = size_q[0] ? bank_rd[0] : bank_rd[1];
        if (size_q < SW'(4)) r4 = '0;
        if (size_q < SW'(5)) r5 = '0;
    end

    always_comb begin
        tos_d  = tos_q;
        nos_d  = nos_q;
        sh_d   = sh_q;
        size_d = size_q;
        trap_d = trap_q;
        wr_en  = 1'b0;
        if (op_valid && (trap_q == TRAP_NONE)) begin
            case (op)
                STACK_OP_PUSH: begin
                    if (size_q == SW'(DEPTH)) begin
                        trap_d = TRAP_STACK_OVERFLOW;
                    end else begin
                        tos_d  = din;
                        nos_d  = tos_q;
                        sh_d   = nos_q;
                        size_d = size_q + SW'(1);
                        wr_en  = (size_q >= SW'(2));
                    end
                end
                STACK_OP_POP, STACK_OP_UNARY: begin
                    if (size_q == '0) begin
                        trap_d = TRAP_STACK_UNDERFLOW;
                    end else if (op == STACK_OP_UNARY) begin
                        tos_d = din;
                    end else begin
                        tos_d  = nos_q;
                        nos_d  = sh_q;
                        sh_d   = r4;
                        size_d = size_q - SW'(1);
                    end
                end
                STACK_OP_BINARY, STACK_OP_DROP2: begin
                    if (size_q < SW'(2)) begin
                        trap_d = TRAP_STACK_UNDERFLOW;
                    end else if (op == STACK_OP_BINARY) begin
                        tos_d  = din;
                        nos_d  = sh_q;
                        sh_d   = r4;
                        size_d = size_q - SW'(1);
                    end else begin
                        tos_d  = sh_q;
                        nos_d  = r4;
                        sh_d   = r5;
                        size_d = size_q - SW'(2);
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tos_q  <= '0;
            nos_q  <= '0;
            sh_q   <= '0;
            size_q <= '0;
            trap_q <= TRAP_NONE;
        end else begin
            tos_q  <= tos_d;
            nos_q  <= nos_d;
            sh_q   <= sh_d;
            size_q <= size_d;
            trap_q <= trap_d;
        end
    end

    assign tos   = tos_q;
    assign nos   = nos_q;
    assign size  = size_q;
    assign empty = (size_q == '0);
    assign full  = (size_q == SW'(DEPTH));
    assign trap  = trap_q;

`ifdef OPERAND_STACK_HWM_EN
    logic [SW-1:0] hwm_q, hwm_d;

    assign hwm_d = (size_d > hwm_q) ? size_d : hwm_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hwm_q <= '0;
        end else begin
            hwm_q <= hwm_d;
        end
    end

    assign hwm = hwm_q;
`endif
endmodule
